uart_tx_cfg: RTL and testbench

Next-generation UART transmitter for the serial link. It adds a parametrised TX FIFO and a runtime frame format: data length, parity mode, stop-bit count and bit period are all taken from the config word. It sits between the host-side byte producer and the board TX pin. It drives idle-high serial data and reports active, done and FIFO status back to the producer.

---
 rtl/uart_tx_cfg.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a TX FIFO and a frame format taken at runtime from a config word.
// Each frame latches DIV, data length, parity and stop-bit count when it leaves IDLE.
module uart_tx_cfg #(
   parameter int unsigned UART_DATA_WIDTH   = 9,
   parameter int unsigned CONFIG_DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH        = 16,
   parameter int unsigned FIFO_AW           = 4
) (
   input  logic                         i_Clock,
   input  logic                         i_Reset_n,
   input  logic [CONFIG_DATA_WIDTH-1:0] uart_config_data,
   input  logic                         i_Tx_DV,
   input  logic [UART_DATA_WIDTH-1:0]   i_Tx_Byte,
   output logic                         o_Tx_Ready,
   output logic                         o_Tx_Active,
   output logic                         o_Tx_Serial,
   output logic                         o_Tx_Done,
   output logic [FIFO_AW:0]             o_Fifo_Count
);

   localparam int unsigned DIV_W = 16;
   localparam int unsigned NB_W  = 4;
   localparam int unsigned CNT_W = FIFO_AW + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // FIFO storage and pointers
   logic [UART_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]         r_wr_ptr;
   logic [FIFO_AW-1:0]         r_rd_ptr;
   logic [CNT_W-1:0]           r_count;

   // Transmit engine
   state_t                     r_state;
   logic [UART_DATA_WIDTH-1:0] r_shift;
   logic [DIV_W-1:0]           r_div;
   logic [NB_W-1:0]            r_nbits;
   logic [1:0]                 r_par_mode;
   logic                       r_stop2;
   logic [DIV_W-1:0]           r_clk_cnt;
   logic [NB_W-1:0]            r_bit_idx;
   logic                       r_parity;
   logic                       r_stop_idx;
   logic                       r_serial;
   logic                       r_active;
   logic                       r_done;

   logic                       w_full;
   logic                       w_empty;
   logic                       w_pop;
   logic                       w_push;
   logic                       w_bit_end;
   logic [DIV_W-1:0]           w_cnt_next;
   logic [NB_W-1:0]            w_cfg_n;
   logic [NB_W-1:0]            w_nbits;
   logic                       w_par_acc;
   logic                       w_par_bit;
   logic                       w_unused;

   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_pop      = (r_state == S_IDLE) && !w_empty;
   assign w_push     = i_Tx_DV && (!w_full || w_pop);
   assign w_bit_end  = (r_clk_cnt == r_div);
   assign w_cnt_next = w_bit_end ? '0 : r_clk_cnt + DIV_W'(1);
   assign w_cfg_n    = uart_config_data[19:16];
   assign w_par_acc  = r_parity ^ r_shift[0];
   assign w_unused   = ^{uart_config_data[CONFIG_DATA_WIDTH-1:23]};

   // Clamp the requested data length into the supported 5..UART_DATA_WIDTH range
   always_comb begin
      w_nbits = w_cfg_n;
      if (w_cfg_n < NB_W'(5))
         w_nbits = NB_W'(5);
      else if (32'(w_cfg_n) > UART_DATA_WIDTH)
         w_nbits = NB_W'(UART_DATA_WIDTH);
   end

   always_comb begin
      case (r_par_mode)
         2'b01:   w_par_bit = w_par_acc;
         2'b10:   w_par_bit = ~w_par_acc;
         default: w_par_bit = 1'b1;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_Tx_Byte;
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Frame sequencer; line, active and done are all registered here
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_div      <= '0;
         r_nbits    <= '0;
         r_par_mode <= '0;
         r_stop2    <= 1'b0;
         r_clk_cnt  <= '0;
         r_bit_idx  <= '0;
         r_parity   <= 1'b0;
         r_stop_idx <= 1'b0;
         r_serial   <= 1'b1;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_serial <= 1'b1;
               r_active <= 1'b0;
               if (w_pop) begin
                  r_shift    <= r_mem[r_rd_ptr];
                  r_div      <= uart_config_data[15:0];
                  r_nbits    <= w_nbits;
                  r_par_mode <= uart_config_data[21:20];
                  r_stop2    <= uart_config_data[22];
                  r_clk_cnt  <= '0;
                  r_bit_idx  <= '0;
                  r_parity   <= 1'b0;
                  r_stop_idx <= 1'b0;
                  r_serial   <= 1'b0;
                  r_active   <= 1'b1;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               r_clk_cnt <= w_cnt_next;
               if (w_bit_end) begin
                  r_serial <= r_shift[0];
                  r_state  <= S_DATA;
               end
            end
            S_DATA: begin
               r_clk_cnt <= w_cnt_next;
               if (w_bit_end) begin
                  r_parity  <= w_par_acc;
                  r_shift   <= r_shift >> 1;
                  r_bit_idx <= r_bit_idx + NB_W'(1);
                  if (r_bit_idx == r_nbits - NB_W'(1)) begin
                     if (r_par_mode == 2'b00) begin
                        r_serial <= 1'b1;
                        r_state  <= S_STOP;
                     end else begin
                        r_serial <= w_par_bit;
                        r_state  <= S_PARITY;
                     end
                  end else begin
                     r_serial <= r_shift[1];
                  end
               end
            end
            S_PARITY: begin
               r_clk_cnt <= w_cnt_next;
               if (w_bit_end) begin
                  r_serial <= 1'b1;
                  r_state  <= S_STOP;
               end
            end
            S_STOP: begin
               r_clk_cnt <= w_cnt_next;
               r_serial  <= 1'b1;
               if (w_bit_end) begin
                  if (r_stop2 && !r_stop_idx) begin
                     r_stop_idx <= 1'b1;
                  end else begin
                     r_done   <= 1'b1;
                     r_active <= 1'b0;
                     r_state  <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_serial  <= 1'b1;
               r_active  <= 1'b0;
               r_clk_cnt <= '0;
            end
         endcase
      end
   end

   assign o_Tx_Ready   = ~w_full;
   assign o_Tx_Active  = r_active;
   assign o_Tx_Serial  = r_serial;
   assign o_Tx_Done    = r_done;
   assign o_Fifo_Count = r_count;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed and randomized frames for uart_tx_cfg, checked cycle by cycle against a
// waveform built from the frame-format rules (start, N data bits LSB first, parity, stops).
module tb_uart_tx_cfg;

   localparam int unsigned UDW   = 9;
   localparam int unsigned CDW   = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [CDW-1:0] cfg;
   logic           tx_dv;
   logic [UDW-1:0] tx_byte;
   logic           tx_ready;
   logic           tx_active;
   logic           tx_serial;
   logic           tx_done;
   logic [AW:0]    fifo_count;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_cfg #(
      .UART_DATA_WIDTH  (UDW),
      .CONFIG_DATA_WIDTH(CDW),
      .FIFO_DEPTH       (DEPTH),
      .FIFO_AW          (AW)
   ) dut (
      .i_Clock         (clk),
      .i_Reset_n       (rst_n),
      .uart_config_data(cfg),
      .i_Tx_DV         (tx_dv),
      .i_Tx_Byte       (tx_byte),
      .o_Tx_Ready      (tx_ready),
      .o_Tx_Active     (tx_active),
      .o_Tx_Serial     (tx_serial),
      .o_Tx_Done       (tx_done),
      .o_Fifo_Count    (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [UDW-1:0] b);
      tx_dv   = 1'b1;
      tx_byte = b;
      step();
      tx_dv   = 1'b0;
   endtask

   function automatic logic [31:0] mk_cfg(input logic [15:0] div, input logic [3:0] n,
                                          input logic [1:0] par, input logic stop2,
                                          input logic [8:0] junk);
      return {junk, stop2, par, n, div};
   endfunction

   // Builds the expected line waveform for one frame, waits for it to start, then
   // compares every cycle; optionally pushes bytes or changes config mid-frame.
   task automatic check_frame(input logic [31:0] fcfg, input logic [UDW-1:0] data,
                              input int max_wait, input int npush,
                              input logic [UDW-1:0] p0, input logic [UDW-1:0] p1,
                              input int exp_cnt, input bit chg, input logic [31:0] new_cfg);
      int   div, n, par, ones, w;
      bit   stop2;
      logic pbit;
      logic q[$];
      div   = int'(fcfg[15:0]);
      n     = int'(fcfg[19:16]);
      if (n < 5) n = 5;
      if (n > int'(UDW)) n = int'(UDW);
      par   = int'(fcfg[21:20]);
      stop2 = fcfg[22];
      ones  = 0;
      for (int i = 0; i < n; i++) ones += int'(data[i]);
      pbit = (par == 1) ? logic'(ones % 2) : (par == 2) ? logic'(1 - ones % 2) : 1'b1;
      repeat (div + 1) q.push_back(1'b0);
      for (int i = 0; i < n; i++) repeat (div + 1) q.push_back(data[i]);
      if (par != 0) repeat (div + 1) q.push_back(pbit);
      repeat ((stop2 ? 2 : 1) * (div + 1)) q.push_back(1'b1);

      w = 0;
      while (tx_active !== 1'b1 && w < max_wait) begin
         step();
         w++;
      end
      chk("frame_start", 32'(tx_active), 32'd1);
      if (tx_active !== 1'b1) return;

      for (int k = 0; k < q.size(); k++) begin
         chk($sformatf("serial[%0d]", k), 32'(tx_serial), 32'(q[k]));
         chk($sformatf("active[%0d]", k), 32'(tx_active), 32'd1);
         chk($sformatf("done_low[%0d]", k), 32'(tx_done), 32'd0);
         if (k == q.size() - 1)
            chk("count_end", 32'(fifo_count), 32'(exp_cnt));
         if (k < npush) begin
            tx_dv   = 1'b1;
            tx_byte = (k == 0) ? p0 : p1;
         end else begin
            tx_dv = 1'b0;
         end
         if (chg && k == 2) cfg = new_cfg;
         step();
      end
      chk("done_pulse", 32'(tx_done), 32'd1);
      chk("done_inactive", 32'(tx_active), 32'd0);
      chk("done_line", 32'(tx_serial), 32'd1);
      step();
      chk("done_single", 32'(tx_done), 32'd0);
   endtask

   initial begin
      logic [31:0]    c_a, c_b;
      logic [UDW-1:0] d;

      rst_n   = 1'b0;
      cfg     = '0;
      tx_dv   = 1'b0;
      tx_byte = '0;
      step();
      step();
      chk("rst_serial", 32'(tx_serial), 32'd1);
      chk("rst_active", 32'(tx_active), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_count", 32'(fifo_count), 32'd0);
      rst_n = 1'b1;
      step();

      // 8N1, 4 clocks per bit
      cfg = mk_cfg(16'd3, 4'd8, 2'b00, 1'b0, 9'd0);
      push(9'h0A5);
      check_frame(cfg, 9'h0A5, 3, 0, '0, '0, 0, 1'b0, '0);

      // 7E1 back-to-back frames; two bytes queued during a lead-in frame
      cfg = mk_cfg(16'd1, 4'd7, 2'b01, 1'b0, 9'd0);
      push(9'h055);
      check_frame(cfg, 9'h055, 3, 2, 9'h003, 9'h007, 2, 1'b0, '0);
      check_frame(cfg, 9'h003, 0, 0, '0, '0, 1, 1'b0, '0);
      check_frame(cfg, 9'h007, 0, 0, '0, '0, 0, 1'b0, '0);

      // 9O2 at 1 clock per bit
      cfg = mk_cfg(16'd0, 4'd9, 2'b10, 1'b1, 9'd0);
      push(9'h1FF);
      check_frame(cfg, 9'h1FF, 3, 0, '0, '0, 0, 1'b0, '0);

      // Config change mid-frame only affects the following frame
      c_a = mk_cfg(16'd3, 4'd8, 2'b00, 1'b0, 9'd0);
      c_b = mk_cfg(16'd7, 4'd8, 2'b00, 1'b0, 9'd0);
      cfg = c_a;
      push(9'h03C);
      check_frame(c_a, 9'h03C, 3, 1, 9'h0C3, '0, 1, 1'b1, c_b);
      check_frame(c_b, 9'h0C3, 0, 0, '0, '0, 0, 1'b0, '0);

      // Random formats, including out-of-range data lengths and junk upper bits
      for (int it = 0; it < 8; it++) begin
         cfg = mk_cfg(16'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 9'($urandom));
         d   = UDW'($urandom);
         push(d);
         check_frame(cfg, d, 3, 0, '0, '0, 0, 1'b0, '0);
      end

      // Fill the FIFO behind a stalled frame
      cfg   = mk_cfg(16'hFFFF, 4'd8, 2'b00, 1'b0, 9'd0);
      tx_dv = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tx_byte = UDW'(i);
         step();
      end
      chk("fill15_count", 32'(fifo_count), 32'd15);
      chk("fill15_ready", 32'(tx_ready), 32'd1);
      tx_byte = 9'h011;
      step();
      tx_dv = 1'b0;
      chk("full_count", 32'(fifo_count), 32'd16);
      chk("full_ready", 32'(tx_ready), 32'd0);
      chk("full_line", 32'(tx_serial), 32'd0);
      push(9'h1AA);
      chk("drop_count", 32'(fifo_count), 32'd16);
      chk("drop_ready", 32'(tx_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_full_count", 32'(fifo_count), 32'd0);
      chk("arst_full_ready", 32'(tx_ready), 32'd1);
      chk("arst_full_line", 32'(tx_serial), 32'd1);
      step();
      rst_n = 1'b1;
      step();

      // Reset in the middle of the data bits
      cfg = mk_cfg(16'd3, 4'd8, 2'b00, 1'b0, 9'd0);
      push(9'h05A);
      push(9'h00F);
      repeat (6) step();
      chk("pre_rst_active", 32'(tx_active), 32'd1);
      chk("pre_rst_bit0", 32'(tx_serial), 32'd0);
      chk("pre_rst_count", 32'(fifo_count), 32'd1);
      rst_n = 1'b0;
      #2;
      chk("arst_line", 32'(tx_serial), 32'd1);
      chk("arst_active", 32'(tx_active), 32'd0);
      chk("arst_count", 32'(fifo_count), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         chk("post_rst_line", 32'(tx_serial), 32'd1);
         chk("post_rst_done", 32'(tx_done), 32'd0);
         chk("post_rst_active", 32'(tx_active), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
